// File: rtl/aes192_job_sched.sv
// rtl/aes192_job_sched.sv - round-robin job sequencer for a shared aes192 core
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req0_* / req1_*       per-requester job port: valid/ready handshake,
//                         decrypt flag, 128-bit data block, 192-bit key
//   core_load_o           one-cycle load pulse to the core
//   core_decrypt_o/data_o/key_o  registered operands held for the whole job
//   core_ready_i/data_i   core completion pulse and its result
//   res_valid_o/ready_i   result handshake
//   res_id_o/data_o/timeout_o  result tag, block and abort flag
//   busy_o                high whenever a job is in flight
module aes192_job_sched #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic         req0_decrypt_i,
    input  logic [127:0] req0_data_i,
    input  logic [191:0] req0_key_i,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic         req1_decrypt_i,
    input  logic [127:0] req1_data_i,
    input  logic [191:0] req1_key_i,
    output logic         core_load_o,
    output logic         core_decrypt_o,
    output logic [127:0] core_data_o,
    output logic [191:0] core_key_o,
    input  logic         core_ready_i,
    input  logic [127:0] core_data_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic         res_id_o,
    output logic [127:0] res_data_o,
    output logic         res_timeout_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - CNT_W'(1);

    state_t           state;
    logic             last_grant;
    logic             sel_id;
    logic [CNT_W-1:0] cnt;
    logic             grant0;
    logic             grant1;

    // Requester 1 wins when it is alone, or when both are asking and
    // requester 0 was the last one served.
    assign grant1 = req1_valid_i & (~req0_valid_i | ~last_grant);
    assign grant0 = req0_valid_i & ~grant1;

    assign req0_ready_o = (state == IDLE) & grant0;
    assign req1_ready_o = (state == IDLE) & grant1;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            sel_id         <= 1'b0;
            cnt            <= '0;
            core_load_o    <= 1'b0;
            core_decrypt_o <= 1'b0;
            core_data_o    <= '0;
            core_key_o     <= '0;
            res_valid_o    <= 1'b0;
            res_id_o       <= 1'b0;
            res_data_o     <= '0;
            res_timeout_o  <= 1'b0;
        end else begin
            core_load_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        core_decrypt_o <= grant1 ? req1_decrypt_i : req0_decrypt_i;
                        core_data_o    <= grant1 ? req1_data_i    : req0_data_i;
                        core_key_o     <= grant1 ? req1_key_i     : req0_key_i;
                        sel_id         <= grant1;
                        last_grant     <= grant1;
                        core_load_o    <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    // A completion in the timeout cycle still counts as a
                    // normal result.
                    if (core_ready_i) begin
                        res_data_o    <= core_data_i;
                        res_timeout_o <= 1'b0;
                        res_id_o      <= sel_id;
                        res_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_data_o    <= '0;
                        res_timeout_o <= 1'b1;
                        res_id_o      <= sel_id;
                        res_valid_o   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes192_job_sched.sv
// tb/tb_aes192_job_sched.sv - directed bench for aes192_job_sched with a stub core
module tb_aes192_job_sched;

    localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid_i, req0_ready_o, req0_decrypt_i;
    logic [127:0] req0_data_i;
    logic [191:0] req0_key_i;
    logic         req1_valid_i, req1_ready_o, req1_decrypt_i;
    logic [127:0] req1_data_i;
    logic [191:0] req1_key_i;
    logic         core_load_o, core_decrypt_o;
    logic [127:0] core_data_o;
    logic [191:0] core_key_o;
    logic         core_ready_i;
    logic [127:0] core_data_i;
    logic         res_valid_o, res_ready_i, res_id_o, res_timeout_o, busy_o;
    logic [127:0] res_data_o;

    int tests = 0;
    int fails = 0;
    int stub_delay = 3;
    int cnt0 = 0;
    int cnt1 = 0;
    int grants[$];

    always #5 clk = ~clk;

    aes192_job_sched #(.TIMEOUT(16'd8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_decrypt_i(req0_decrypt_i), .req0_data_i(req0_data_i), .req0_key_i(req0_key_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_decrypt_i(req1_decrypt_i), .req1_data_i(req1_data_i), .req1_key_i(req1_key_i),
        .core_load_o(core_load_o), .core_decrypt_o(core_decrypt_o),
        .core_data_o(core_data_o), .core_key_o(core_key_o),
        .core_ready_i(core_ready_i), .core_data_i(core_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
        .res_data_o(res_data_o), .res_timeout_o(res_timeout_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub core: known-answer vector for the reference key, otherwise data ^ key[127:0].
    function automatic logic [127:0] model(input logic dec, input logic [127:0] d, input logic [191:0] k);
        if (!dec && d == PT && k == KEY) return CT;
        if (dec && d == CT && k == KEY) return PT;
        return d ^ k[127:0];
    endfunction

    // Completion pulse lands in BUSY cycle stub_delay; 0 means never.
    initial begin
        int cd;
        cd = 0;
        core_ready_i = 1'b0;
        core_data_i  = '0;
        forever begin
            @(negedge clk);
            core_ready_i = 1'b0;
            core_data_i  = '0;
            if (reset) cd = 0;
            else if (core_load_o) cd = stub_delay;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_ready_i = 1'b1;
                    core_data_i  = model(core_decrypt_o, core_data_o, core_key_o);
                end
            end
        end
    end

    // Accept monitor, sampled after all negedge drivers have settled.
    initial forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (req0_valid_i && req0_ready_o) begin grants.push_back(0); cnt0++; end
            if (req1_valid_i && req1_ready_o) begin grants.push_back(1); cnt1++; end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_job(input bit id, input bit dec, input logic [127:0] d, input logic [191:0] k,
                             input string tag);
        if (id) begin
            req1_valid_i = 1'b1; req1_decrypt_i = dec; req1_data_i = d; req1_key_i = k;
        end else begin
            req0_valid_i = 1'b1; req0_decrypt_i = dec; req0_data_i = d; req0_key_i = k;
        end
        #1;
        check({tag, "_ready"}, {req1_ready_o, req0_ready_o}, id ? 2'b10 : 2'b01);
        @(negedge clk);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        check({tag, "_load"}, {core_load_o, busy_o}, 2'b11);
        check({tag, "_core_ops"}, {core_decrypt_o, core_data_o}, {dec, d});
        check({tag, "_core_key"}, core_key_o, k);
    endtask

    task automatic wait_res(input string tag, output int n);
        n = 0;
        while (!res_valid_o && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_load_width"}, core_load_o, 1'b0);
        end
        if (!res_valid_o) check({tag, "_res_wait"}, res_valid_o, 1'b1);
    endtask

    task automatic finish_job(input string tag);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check({tag, "_after_hs"}, {res_valid_o, busy_o}, 2'b00);
    endtask

    task automatic run_job(input bit id, input bit dec, input logic [127:0] d, input logic [191:0] k,
                           input logic [127:0] exp_d, input bit exp_to, input int exp_n, input string tag);
        int n;
        start_job(id, dec, d, k, tag);
        wait_res(tag, n);
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_res"}, {res_id_o, res_timeout_o, res_data_o}, {id, exp_to, exp_d});
        check({tag, "_key_held"}, core_key_o, k);
        finish_job(tag);
    endtask

    initial begin
        int n;
        bit bad_stable, bad_accept;
        logic [129:0] held;
        logic [3:0] order;

        reset = 1'b1;
        req0_valid_i = 0; req0_decrypt_i = 0; req0_data_i = '0; req0_key_i = '0;
        req1_valid_i = 0; req1_decrypt_i = 0; req1_data_i = '0; req1_key_i = '0;
        res_ready_i = 0;
        #1;
        check("rst_core", {core_load_o, core_decrypt_o, core_data_o}, '0);
        check("rst_key", core_key_o, '0);
        check("rst_res", {res_valid_o, res_id_o, res_timeout_o, res_data_o, busy_o}, '0);
        do_reset();
        #1;
        check("idle_no_ready", {req1_ready_o, req0_ready_o, busy_o}, 3'b000);

        // Normal jobs: stub answers in BUSY cycle 3, result one cycle later.
        stub_delay = 3;
        run_job(1'b0, 1'b0, PT, KEY, CT, 1'b0, 4, "enc_req0");
        run_job(1'b1, 1'b1, CT, KEY, PT, 1'b0, 4, "dec_req1");

        // Both requesters valid from reset: strict alternation starting at 0.
        do_reset();
        grants.delete();
        cnt0 = 0; cnt1 = 0;
        req0_valid_i = 1'b1; req0_decrypt_i = 1'b0; req0_data_i = PT; req0_key_i = KEY;
        req1_valid_i = 1'b1; req1_decrypt_i = 1'b1; req1_data_i = CT; req1_key_i = KEY;
        res_ready_i = 1'b1;
        n = 0;
        while (grants.size() < 4 && n < 100) begin @(negedge clk); n++; end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        n = 0;
        while (busy_o && n < 40) begin @(negedge clk); n++; end
        res_ready_i = 1'b0;
        check("rr_grants", grants.size(), 4);
        order = 4'hf;
        for (int i = 0; i < 4; i++) if (i < grants.size()) order[i] = grants[i][0];
        check("rr_order", order, 4'b1010);
        check("rr_counts", {cnt0[7:0], cnt1[7:0]}, {8'd2, 8'd2});
        check("rr_drained", busy_o, 1'b0);

        // Result backpressure for 20 cycles.
        start_job(1'b1, 1'b1, 128'h0, KEY, "bp");
        wait_res("bp", n);
        held = {res_id_o, res_timeout_o, res_data_o};
        check("bp_res", held, {1'b1, 1'b0, 128'h08090a0b0c0d0e0f1011121314151617});
        req0_valid_i = 1'b1; req0_decrypt_i = 1'b0; req0_data_i = PT; req0_key_i = KEY;
        bad_stable = 0;
        bad_accept = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!res_valid_o || {res_id_o, res_timeout_o, res_data_o} !== held) bad_stable = 1;
            if (req0_ready_o || req1_ready_o || !busy_o) bad_accept = 1;
            @(negedge clk);
        end
        check("bp_stable", bad_stable, 1'b0);
        check("bp_no_accept", bad_accept, 1'b0);
        check("bp_still_valid", res_valid_o, 1'b1);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        #1;
        check("bp_idle_after_hs", {res_valid_o, busy_o, req0_ready_o}, 3'b001);
        req0_valid_i = 1'b0;
        @(negedge clk);
        check("bp_no_extra_job", busy_o, 1'b0);

        // Timeout after 8 BUSY cycles, then completion exactly in the 8th cycle.
        stub_delay = 0;
        run_job(1'b0, 1'b0, PT, KEY, 128'h0, 1'b1, 9, "tmo");
        stub_delay = 8;
        run_job(1'b1, 1'b0, 128'h1, KEY, 128'h08090a0b0c0d0e0f1011121314151616, 1'b0, 9, "tmo_tie");

        // Asynchronous reset in the middle of a job.
        stub_delay = 0;
        start_job(1'b1, 1'b1, CT, KEY, "rst_busy");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstb_core", {core_load_o, core_decrypt_o, core_data_o}, '0);
        check("rstb_key", core_key_o, '0);
        check("rstb_res", {res_valid_o, res_id_o, res_timeout_o, res_data_o, busy_o}, '0);
        @(negedge clk);
        reset = 1'b0;
        stub_delay = 3;
        req0_valid_i = 1'b1; req0_decrypt_i = 1'b0; req0_data_i = PT; req0_key_i = KEY;
        req1_valid_i = 1'b1; req1_decrypt_i = 1'b1; req1_data_i = CT; req1_key_i = KEY;
        #1;
        check("rstb_first_grant", {req1_ready_o, req0_ready_o, res_valid_o}, 3'b010);
        @(negedge clk);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        wait_res("rstb_job", n);
        check("rstb_job_res", {res_id_o, res_timeout_o, res_data_o}, {1'b0, 1'b0, CT});
        finish_job("rstb_job");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
